beam_power_accum: RTL and testbench

Accumulates per-steering-bin beam power from the beamformed sample stream and writes one DATA_WIDTH power word per bin into the power RAM, in bin order 0..2^ADDR_WIDTH-1. After the last bin of a frame is written, it pulses the peak-search start and stalls the sample stream until the search reports a valid result. The power RAM's write port is driven by this block; its read port is owned by the downstream peak search.

---
 rtl/beam_power_accum.sv | 113 +++++++++++
 tb/tb_beam_power_accum.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/beam_power_accum.sv
// Per-bin beam power accumulator: squares and sums SAMPLES_PER_BIN samples per bin, writes one
// power word per bin, then stalls for the peak search. Define BEAM_POWER_SATURATE_EN to saturate instead of wrap.
module beam_power_accum #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 12,
  parameter int SAMPLE_WIDTH    = 12,
  parameter int SAMPLES_PER_BIN = 16,
  parameter int SHIFT           = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sampleValid,
  output logic                           sampleReady,
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  output logic                           wrEn,
  output logic [ADDR_WIDTH-1:0]          wrAddr,
  output logic [DATA_WIDTH-1:0]          wrData,
  output logic                           argmaxStart,
  input  logic                           argmaxValid,
  output logic                           binOverflow
);

  localparam int CNT_W = $clog2(SAMPLES_PER_BIN);
  localparam int SQ_W  = 2 * SAMPLE_WIDTH;
  localparam int ACC_W = SQ_W + CNT_W;

  typedef enum logic [2:0] {ACCUM, FLUSH, START, WAIT_LOW, WAIT_HIGH} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [ADDR_WIDTH-1:0]   bin;
  logic [ACC_W-1:0]        acc;
  logic signed [SQ_W-1:0]  prod;
  logic [ACC_W-1:0]        sum;
  logic [ACC_W-1:0]        shifted;
  logic                    ovf;
  logic [DATA_WIDTH-1:0]   word;
  logic                    accept;
  logic                    last_smp;
  logic                    last_bin;

  assign accept   = sampleValid & sampleReady;
  assign last_smp = &cnt;
  assign last_bin = &bin;

  // Square is non-negative, so the signed product can be zero-extended into the accumulator.
  assign prod    = SQ_W'(sample) * SQ_W'(sample);
  assign sum     = acc + {{CNT_W{1'b0}}, prod};
  assign shifted = sum >> SHIFT;
  assign ovf     = (shifted >> DATA_WIDTH) != '0;

`ifdef BEAM_POWER_SATURATE_EN
  assign word = ovf ? '1 : DATA_WIDTH'(shifted);
`else
  assign word = DATA_WIDTH'(shifted);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ACCUM;
      cnt         <= '0;
      bin         <= '0;
      acc         <= '0;
      sampleReady <= 1'b0;
      wrEn        <= 1'b0;
      wrAddr      <= '0;
      wrData      <= '0;
      argmaxStart <= 1'b0;
      binOverflow <= 1'b0;
    end else begin
      wrEn        <= 1'b0;
      argmaxStart <= 1'b0;
      case (state)
        ACCUM: begin
          sampleReady <= 1'b1;
          if (accept) begin
            cnt <= cnt + CNT_W'(1);
            if (last_smp) begin
              acc    <= '0;
              wrEn   <= 1'b1;
              wrAddr <= bin;
              wrData <= word;
              bin    <= bin + ADDR_WIDTH'(1);
              if (ovf) binOverflow <= 1'b1;
              if (last_bin) begin
                state       <= FLUSH;
                sampleReady <= 1'b0;
              end
            end else begin
              acc <= sum;
            end
          end
        end
        FLUSH: begin
          state       <= START;
          argmaxStart <= 1'b1;
        end
        START: state <= WAIT_LOW;
        // A valid still high from the previous search must drop before a new result counts.
        WAIT_LOW: if (!argmaxValid) state <= WAIT_HIGH;
        WAIT_HIGH: begin
          if (argmaxValid) begin
            state       <= ACCUM;
            sampleReady <= 1'b1;
            binOverflow <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_beam_power_accum.sv
// Directed + randomized bench for beam_power_accum; expected power words come from a
// sum-of-squares model of each bin's samples.
module tb_beam_power_accum;
  localparam int DW = 8, AW = 2, SPB = 4, SH = 0, SW = 12;
  localparam int NBINS = 1 << AW;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 sampleValid = 1'b0;
  logic                 sampleReady;
  logic signed [SW-1:0] sample = '0;
  logic                 wrEn;
  logic [AW-1:0]        wrAddr;
  logic [DW-1:0]        wrData;
  logic                 argmaxStart;
  logic                 argmaxValid = 1'b0;
  logic                 binOverflow;

  int n_assert = 0, n_fail = 0;
  int obs_wr = 0, obs_start = 0, exp_wr = 0, exp_start = 0;
  bit both_seen = 0;

  longint m_acc = 0;
  int     m_cnt = 0, m_bin = 0;
  bit     m_ovf = 0;

  always #5 clk = ~clk;

  beam_power_accum #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW),
    .SAMPLES_PER_BIN(SPB), .SHIFT(SH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sampleValid(sampleValid), .sampleReady(sampleReady),
    .sample(sample), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .argmaxStart(argmaxStart), .argmaxValid(argmaxValid), .binOverflow(binOverflow)
  );

  always @(negedge clk) begin
    if (wrEn) obs_wr++;
    if (argmaxStart) obs_start++;
    if (wrEn && argmaxStart) both_seen = 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint exp_word(input longint a);
    longint s;
    s = a >> SH;
`ifdef BEAM_POWER_SATURATE_EN
    if (s > (1 << DW) - 1) return (1 << DW) - 1;
    return s;
`else
    return s & ((1 << DW) - 1);
`endif
  endfunction

  function automatic int rand_sample();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 16)) - 8;
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called and returns at a negedge; checks the write (and frame-end pulse) the model predicts.
  task automatic send(input int s);
    int n;
    longint sh;
    n = 0;
    sample = SW'(s);
    sampleValid = 1'b1;
    while (!sampleReady && n < 200) begin @(negedge clk); n++; end
    if (!sampleReady) begin
      check("accept_timeout", 0, 1);
      sampleValid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    sampleValid = 1'b0;
    m_acc += longint'(s) * longint'(s);
    m_cnt++;
    if (m_cnt == SPB) begin
      sh = m_acc >> SH;
      if (sh > (1 << DW) - 1) m_ovf = 1;
      check("wrEn", wrEn, 1);
      check("wrAddr", wrAddr, m_bin);
      check("wrData", wrData, exp_word(m_acc));
      check("binOverflow", binOverflow, m_ovf);
      exp_wr++;
      m_acc = 0;
      m_cnt = 0;
      if (m_bin == NBINS - 1) begin
        check("ready_flush", sampleReady, 0);
        check("start_early", argmaxStart, 0);
        @(negedge clk);
        check("argmaxStart", argmaxStart, 1);
        check("wrEn_in_start", wrEn, 0);
        check("ready_start", sampleReady, 0);
        exp_start++;
        m_bin = 0;
      end else begin
        m_bin++;
      end
    end else begin
      check("wrEn_idle", wrEn, 0);
    end
  endtask

  // Entered at the negedge of the START cycle.
  task automatic search(input int hi, input int lo);
    repeat (hi) begin
      @(negedge clk);
      check("ready_hi", sampleReady, 0);
      check("ovf_hold", binOverflow, m_ovf);
    end
    argmaxValid = 1'b0;
    repeat (lo) begin
      @(negedge clk);
      check("ready_lo", sampleReady, 0);
      check("start_once", argmaxStart, 0);
    end
    argmaxValid = 1'b1;
    @(negedge clk);
    check("ready_back", sampleReady, 1);
    check("ovf_cleared", binOverflow, 0);
    argmaxValid = 1'b0;
    m_ovf = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    idle(2);
    check("rst_ready", sampleReady, 0);
    check("rst_wrEn", wrEn, 0);
    check("rst_wrAddr", wrAddr, 0);
    check("rst_wrData", wrData, 0);
    check("rst_start", argmaxStart, 0);
    check("rst_ovf", binOverflow, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", sampleReady, 1);

    // Frame 1: directed bins 0..2, random bin 3, stale argmaxValid held high
    repeat (4) send(3);
    repeat (4) send(-4);
    repeat (4) send(100);
    argmaxValid = 1'b1;
    for (int i = 0; i < SPB; i++) begin
      idle($urandom_range(0, 2));
      send(rand_sample());
    end
    search(5, 3);

    // Frame 2: random samples with random gaps
    for (int i = 0; i < SPB * NBINS; i++) begin
      idle($urandom_range(0, 3));
      send(rand_sample());
    end
    search(0, $urandom_range(2, 5));

    // Reset in the middle of bin 1
    for (int i = 0; i < 6; i++) send(rand_sample());
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", sampleReady, 0);
    check("mid_rst_wrEn", wrEn, 0);
    check("mid_rst_wrAddr", wrAddr, 0);
    check("mid_rst_wrData", wrData, 0);
    check("mid_rst_start", argmaxStart, 0);
    check("mid_rst_ovf", binOverflow, 0);
    m_acc = 0; m_cnt = 0; m_bin = 0; m_ovf = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_mid_rst", sampleReady, 1);
    for (int i = 0; i < SPB; i++) send(rand_sample());
    idle(4);

    check("wr_pulse_count", obs_wr, exp_wr);
    check("start_pulse_count", obs_start, exp_start);
    check("wr_start_overlap", both_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
